// File: rtl/dpb_pkg.sv
// rtl/dpb_pkg.sv - shared bank header field map and read FSM types for the DPB packet path
package dpb_pkg;

  localparam int FRAME_END_BIT = 63;
  localparam int RANK_MSB      = 59;
  localparam int RANK_LSB      = 52;
  localparam int LINE_MSB      = 46;
  localparam int LINE_LSB      = 40;
  localparam int BYTE_MSB      = 37;
  localparam int BYTE_LSB      = 32;
  localparam int SIGN_MSB      = 31;
  localparam int SIGN_LSB      = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_WAIT,
    ST_HDR_CHK,
    ST_LINE_RD,
    ST_STREAM,
    ST_DONE
  } rd_state_t;

  // 0 encodes a full 16-byte last line; counts above 16 cannot fit a line, so clamp them
  function automatic logic [4:0] last_line_bytes(input logic [5:0] bytecnt);
    if (bytecnt == 6'd0 || bytecnt > 6'd16) return 5'd16;
    return bytecnt[4:0];
  endfunction

endpackage

// File: rtl/dpb_master_rd_if.sv
// rtl/dpb_master_rd_if.sv - UDP transmitter side: packet metadata plus byte stream handshake
interface dpb_master_rd_if;

  logic        o_udp_start;
  logic [15:0] o_udp_len;
  logic [7:0]  o_udp_rank;
  logic        o_udp_frame_end;
  logic [31:0] o_udp_head_sign;
  logic [7:0]  o_udp_data;
  logic        o_udp_de;
  logic        i_udp_ready;

  modport master (
    output o_udp_start, o_udp_len, o_udp_rank, o_udp_frame_end, o_udp_head_sign,
    output o_udp_data, o_udp_de,
    input  i_udp_ready
  );

  modport slave (
    input  o_udp_start, o_udp_len, o_udp_rank, o_udp_frame_end, o_udp_head_sign,
    input  o_udp_data, o_udp_de,
    output i_udp_ready
  );

endinterface

// File: rtl/dpb_line_unpacker.sv
// rtl/dpb_line_unpacker.sv - turns one 128-bit bank line into MSB-first bytes under valid/ready
module dpb_line_unpacker (
  input  logic         i_pclk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [127:0] i_line,
  input  logic [4:0]   i_count,
  output logic [7:0]   o_tdata,
  output logic         o_tvalid,
  output logic         o_tlast,
  input  logic         i_tready
);

  logic [127:0] shift_q;
  logic [4:0]   remaining_q;
  logic         valid_q;
  logic         handshake;

  assign handshake = valid_q && i_tready;

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_q     <= '0;
      remaining_q <= '0;
      valid_q     <= 1'b0;
    end else if (i_load) begin
      shift_q     <= i_line;
      remaining_q <= i_count;
      valid_q     <= (i_count != 5'd0);
    end else if (handshake) begin
      shift_q     <= {shift_q[119:0], 8'h00};
      remaining_q <= remaining_q - 5'd1;
      valid_q     <= (remaining_q != 5'd1);
    end
  end

  assign o_tdata  = shift_q[127:120];
  assign o_tvalid = valid_q;
  assign o_tlast  = (remaining_q == 5'd1);

endmodule

// File: rtl/dpb_master_rd.sv
// rtl/dpb_master_rd.sv - drains one filled DPB bank per request, parses its header, streams the payload
module dpb_master_rd
  import dpb_pkg::*;
#(
  parameter logic [6:0] UDP_FRAME_MAX_SIZE_128 = 7'd91,
  parameter int         RD_LATENCY             = 2
) (
  input  logic        i_pclk,
  input  logic        i_rst_n,
  input  logic        i_buf_req,
  input  logic [1:0]  i_buf_rank,
  output logic        o_buf_done,
  output logic        o_busy,
  output logic        o_error,
  input  logic [63:0] i_dpb_rd_b_rd_data,
  output logic [9:0]  o_dpb_rd_b_addr,
  output logic        o_dpb_rd_b_clk,
  output logic        o_dpb_rd_b_cea,
  output logic        o_dpb_rd_b_ocea,
  output logic        o_dpb_rd_b_rst_n,
  dpb_master_rd_if.master udp
);

  localparam logic [1:0] LAT    = 2'(RD_LATENCY);
  localparam logic [1:0] LAT_P1 = 2'(RD_LATENCY + 1);

  rd_state_t   state;
  logic [1:0]  bank_q;
  logic [6:0]  line_q;
  logic [6:0]  lines_n_q;
  logic [4:0]  last_cnt_q;
  logic [1:0]  wait_cnt;
  logic [63:0] hi_word_q;
  logic        hdr_ok_q;

  logic [6:0]  hdr_n;
  logic [5:0]  hdr_bc;
  logic        hdr_bad;
  logic [15:0] hdr_len;

  logic         up_load;
  logic [127:0] up_line;
  logic [4:0]   up_count;
  logic [7:0]   up_tdata;
  logic         up_tvalid;
  logic         up_tlast;

  assign o_dpb_rd_b_clk   = i_pclk;
  assign o_dpb_rd_b_cea   = 1'b1;
  assign o_dpb_rd_b_ocea  = 1'b1;
  assign o_dpb_rd_b_rst_n = ~i_rst_n;

  // Header fields are decoded straight off the read port so metadata is registered on the capture edge
  assign hdr_n   = i_dpb_rd_b_rd_data[LINE_MSB:LINE_LSB];
  assign hdr_bc  = i_dpb_rd_b_rd_data[BYTE_MSB:BYTE_LSB];
  assign hdr_bad = (hdr_n == 7'd0) || (hdr_n > UDP_FRAME_MAX_SIZE_128);
  assign hdr_len = (({9'd0, hdr_n} - 16'd1) << 4) + {11'd0, last_line_bytes(hdr_bc)};

  assign up_load  = (state == ST_LINE_RD) && (wait_cnt == LAT_P1);
  assign up_line  = {hi_word_q, i_dpb_rd_b_rd_data};
  assign up_count = (line_q == lines_n_q) ? last_cnt_q : 5'd16;

  dpb_line_unpacker u_unpacker (
    .i_pclk   (i_pclk),
    .i_rst_n  (i_rst_n),
    .i_load   (up_load),
    .i_line   (up_line),
    .i_count  (up_count),
    .o_tdata  (up_tdata),
    .o_tvalid (up_tvalid),
    .o_tlast  (up_tlast),
    .i_tready (udp.i_udp_ready)
  );

  assign udp.o_udp_data = up_tdata;
  assign udp.o_udp_de   = up_tvalid;

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state               <= ST_IDLE;
      bank_q              <= '0;
      line_q              <= '0;
      lines_n_q           <= '0;
      last_cnt_q          <= '0;
      wait_cnt            <= '0;
      hi_word_q           <= '0;
      hdr_ok_q            <= 1'b0;
      o_buf_done          <= 1'b0;
      o_busy              <= 1'b0;
      o_error             <= 1'b0;
      o_dpb_rd_b_addr     <= '0;
      udp.o_udp_start     <= 1'b0;
      udp.o_udp_len       <= '0;
      udp.o_udp_rank      <= '0;
      udp.o_udp_frame_end <= 1'b0;
      udp.o_udp_head_sign <= '0;
    end else begin
      o_buf_done      <= 1'b0;
      udp.o_udp_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_buf_req) begin
            bank_q          <= i_buf_rank;
            o_busy          <= 1'b1;
            o_dpb_rd_b_addr <= {i_buf_rank, 7'd0, 1'b0};
            wait_cnt        <= 2'd0;
            state           <= ST_HDR_WAIT;
          end
        end
        ST_HDR_WAIT: begin
          if (wait_cnt == LAT) begin
            wait_cnt <= 2'd0;
            state    <= ST_HDR_CHK;
            hdr_ok_q <= !hdr_bad;
            if (hdr_bad) begin
              o_error    <= 1'b1;
              o_buf_done <= 1'b1;
              o_busy     <= 1'b0;
            end else begin
              udp.o_udp_start     <= 1'b1;
              udp.o_udp_len       <= hdr_len;
              udp.o_udp_rank      <= i_dpb_rd_b_rd_data[RANK_MSB:RANK_LSB];
              udp.o_udp_frame_end <= i_dpb_rd_b_rd_data[FRAME_END_BIT];
              udp.o_udp_head_sign <= i_dpb_rd_b_rd_data[SIGN_MSB:SIGN_LSB];
              lines_n_q           <= hdr_n;
              last_cnt_q          <= last_line_bytes(hdr_bc);
            end
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        ST_HDR_CHK: begin
          if (hdr_ok_q) begin
            line_q          <= 7'd1;
            o_dpb_rd_b_addr <= {bank_q, 7'd1, 1'b0};
            wait_cnt        <= 2'd0;
            state           <= ST_LINE_RD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LINE_RD: begin
          if (wait_cnt == 2'd0) o_dpb_rd_b_addr[0] <= 1'b1;
          if (wait_cnt == LAT) hi_word_q <= i_dpb_rd_b_rd_data;
          if (wait_cnt == LAT_P1) begin
            wait_cnt <= 2'd0;
            state    <= ST_STREAM;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        ST_STREAM: begin
          if (up_tvalid && udp.i_udp_ready && up_tlast) begin
            if (line_q == lines_n_q) begin
              o_buf_done <= 1'b1;
              o_busy     <= 1'b0;
              state      <= ST_DONE;
            end else begin
              line_q          <= line_q + 7'd1;
              o_dpb_rd_b_addr <= {bank_q, line_q + 7'd1, 1'b0};
              wait_cnt        <= 2'd0;
              state           <= ST_LINE_RD;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpb_master_rd.sv
// tb/tb_dpb_master_rd.sv - randomized bench for dpb_master_rd against a bank/byte-queue model
module tb_dpb_master_rd;

  localparam int L = 2;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        buf_req = 1'b0;
  logic [1:0]  buf_rank = 2'd0;
  logic        buf_done, busy, error;
  logic [63:0] rd_data;
  logic [9:0]  addr;
  logic        b_clk, b_cea, b_ocea, b_rst_n;

  dpb_master_rd_if udp ();

  dpb_master_rd #(.UDP_FRAME_MAX_SIZE_128(7'd91), .RD_LATENCY(L)) dut (
    .i_pclk             (pclk),
    .i_rst_n            (rst_n),
    .i_buf_req          (buf_req),
    .i_buf_rank         (buf_rank),
    .o_buf_done         (buf_done),
    .o_busy             (busy),
    .o_error            (error),
    .i_dpb_rd_b_rd_data (rd_data),
    .o_dpb_rd_b_addr    (addr),
    .o_dpb_rd_b_clk     (b_clk),
    .o_dpb_rd_b_cea     (b_cea),
    .o_dpb_rd_b_ocea    (b_ocea),
    .o_dpb_rd_b_rst_n   (b_rst_n),
    .udp                (udp)
  );

  always #5 pclk = ~pclk;

  // BRAM port B: L-stage registered read
  logic [63:0] mem  [0:1023];
  logic [63:0] pipe [0:L-1];
  always @(posedge pclk) begin
    pipe[0] <= mem[addr];
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end
  assign rd_data = pipe[L-1];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge pclk) cyc++;

  bit rnd_ready = 1'b0;
  always @(posedge pclk) begin
    #1;
    udp.i_udp_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic [7:0]  exp_q[$];
  logic [7:0]  rx_log[$];
  int          starts, dones, req_cyc;
  logic [1:0]  cur_bank;
  bit          exp_err, err_sticky;
  logic [15:0] exp_len;
  logic [7:0]  exp_rank;
  logic        exp_fe;
  logic [31:0] exp_sign;
  logic [15:0] cap_len;
  logic [7:0]  cap_rank;
  logic        cap_fe;
  bit          prev_stall;
  logic [7:0]  prev_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge pclk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_de", udp.o_udp_de, 1'b1);
        check("hold_data", udp.o_udp_data, prev_data);
      end
      prev_stall = udp.o_udp_de && !udp.i_udp_ready;
      prev_data  = udp.o_udp_data;
      if (udp.o_udp_de && udp.i_udp_ready) begin
        rx_log.push_back(udp.o_udp_data);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_byte: got %0h expected no byte", udp.o_udp_data);
        end else begin
          check("byte", udp.o_udp_data, exp_q.pop_front());
        end
      end
      if (!busy) check("de_idle", udp.o_udp_de, 1'b0);
      else       check("addr_bank", addr[9:8], cur_bank);
      if (udp.o_udp_start) begin
        starts++;
        cap_len  = udp.o_udp_len;
        cap_rank = udp.o_udp_rank;
        cap_fe   = udp.o_udp_frame_end;
        check("start_latency", cyc - req_cyc, L + 2);
        if (exp_err) begin
          tests++;
          fails++;
          $display("FAIL start_on_error: got start expected none");
        end else begin
          check("udp_len", udp.o_udp_len, exp_len);
          check("udp_rank", udp.o_udp_rank, exp_rank);
          check("udp_frame_end", udp.o_udp_frame_end, exp_fe);
          check("udp_head_sign", udp.o_udp_head_sign, exp_sign);
        end
      end
      if (buf_done) dones++;
    end
  end

  task automatic prep(input int n, input int bc, input logic [7:0] rank, input bit fe,
                      input logic [31:0] sign, input logic [1:0] bank, input bit pattern);
    logic [63:0] hdr;
    int len;
    hdr = {$urandom, $urandom};
    hdr[63]    = fe;
    hdr[59:52] = rank;
    hdr[46:40] = 7'(n);
    hdr[37:32] = 6'(bc);
    hdr[31:0]  = sign;
    mem[{bank, 7'd0, 1'b0}] = hdr;
    exp_err = (n == 0 || n > 91);
    exp_q.delete();
    rx_log.delete();
    starts = 0;
    dones  = 0;
    exp_len = 16'd0;
    if (!exp_err) begin
      len      = (n - 1) * 16 + ((bc == 0) ? 16 : bc);
      exp_len  = 16'(len);
      exp_rank = rank;
      exp_fe   = fe;
      exp_sign = sign;
      for (int l = 1; l <= n; l++)
        for (int h = 0; h < 2; h++)
          mem[{bank, 7'(l), 1'(h)}] = {$urandom, $urandom};
      for (int i = 0; i < len; i++) begin
        logic [7:0] b;
        logic [9:0] a;
        b = pattern ? 8'(8'hA1 + i) : 8'($urandom);
        a = {bank, 7'(i / 16 + 1), 1'((i % 16) / 8)};
        mem[a][63 - 8 * (i % 8) -: 8] = b;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic issue_req(input logic [1:0] bank);
    @(posedge pclk);
    #2;
    buf_req  = 1'b1;
    buf_rank = bank;
    cur_bank = bank;
    req_cyc  = cyc;
    @(posedge pclk);
    #2;
    buf_req = 1'b0;
  endtask

  task automatic run_pkt(input int n, input int bc, input logic [7:0] rank, input bit fe,
                         input logic [31:0] sign, input logic [1:0] bank, input bit pattern,
                         input bit rnd, input bit mid_req);
    int t;
    prep(n, bc, rank, fe, sign, bank, pattern);
    rnd_ready = rnd;
    issue_req(bank);
    if (mid_req) begin
      t = 0;
      while (rx_log.size() < 3 && t < 5000) begin @(posedge pclk); t++; end
      #2;
      buf_req  = 1'b1;
      buf_rank = bank + 2'd1;
      @(posedge pclk);
      #2;
      buf_req = 1'b0;
      @(negedge pclk);
      check("mid_req_busy", busy, 1'b1);
    end
    t = 0;
    while (dones == 0 && t < 20000) begin @(posedge pclk); t++; end
    repeat (8) @(posedge pclk);
    if (exp_err) err_sticky = 1'b1;
    @(negedge pclk);
    check("done_count", dones, 1);
    check("start_count", starts, exp_err ? 0 : 1);
    check("bytes_left", exp_q.size(), 0);
    check("rx_count", rx_log.size(), exp_len);
    check("error_flag", error, err_sticky);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 1024; i++) mem[i] = 64'd0;
    udp.i_udp_ready = 1'b1;
    err_sticky = 1'b0;
    exp_err = 1'b0;
    cur_bank = 2'd0;
    req_cyc = 0;
    repeat (3) @(negedge pclk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", buf_done, 1'b0);
    check("reset_error", error, 1'b0);
    check("reset_de", udp.o_udp_de, 1'b0);
    check("reset_start", udp.o_udp_start, 1'b0);
    rst_n = 1'b1;

    run_pkt(3, 0, 8'd2, 1'b0, 32'h10, 2'd2, 1'b0, 1'b0, 1'b0);
    check("t1_len_lit", cap_len, 16'd48);
    check("t1_rank_lit", cap_rank, 8'd2);

    run_pkt(1, 5, 8'd7, 1'b1, 32'h11, 2'd1, 1'b1, 1'b0, 1'b0);
    check("t2_len_lit", cap_len, 16'd5);
    check("t2_fe_lit", cap_fe, 1'b1);
    check("t2_byte0_lit", rx_log[0], 8'hA1);
    check("t2_byte4_lit", rx_log[4], 8'hA5);

    run_pkt(91, 0, 8'd9, 1'b0, 32'hDEAD_BEEF, 2'd3, 1'b0, 1'b1, 1'b0);
    check("t3_len_lit", cap_len, 16'd1456);

    run_pkt(0, 3, 8'd1, 1'b0, 32'h12, 2'd0, 1'b0, 1'b0, 1'b0);
    run_pkt(92, 3, 8'd1, 1'b0, 32'h13, 2'd1, 1'b0, 1'b0, 1'b0);
    run_pkt(2, 9, 8'd4, 1'b1, 32'h14, 2'd0, 1'b0, 1'b1, 1'b0);

    run_pkt(3, 11, 8'd5, 1'b0, 32'h15, 2'd1, 1'b0, 1'b1, 1'b1);

    prep(20, 7, 8'h33, 1'b0, 32'h55, 2'd3, 1'b0);
    rnd_ready = 1'b1;
    issue_req(2'd3);
    t = 0;
    while (rx_log.size() < 10 && t < 5000) begin @(posedge pclk); t++; end
    @(negedge pclk);
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", buf_done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_de", udp.o_udp_de, 1'b0);
    check("rst_data", udp.o_udp_data, 8'd0);
    check("rst_len", udp.o_udp_len, 16'd0);
    check("rst_addr", addr, 10'd0);
    repeat (3) @(negedge pclk);
    exp_q.delete();
    err_sticky = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge pclk);
    check("rst_no_done", dones, 0);
    run_pkt(4, 13, 8'h21, 1'b1, 32'h77, 2'd3, 1'b0, 1'b1, 1'b0);

    for (int r = 0; r < 10; r++) begin
      int n;
      n = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(92, 127))
                                      : $urandom_range(1, 24);
      run_pkt(n, $urandom_range(0, 16), 8'($urandom), 1'($urandom), $urandom,
              2'($urandom), 1'b0, 1'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
